// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: command-side sequencer for a single combinational ALU.
//   Accepts ADD/SUB/AND/OR/SLL/SRL commands over a valid/ready channel and drives
//   the ALU through one or more passes. Double-width ADD/SUB/AND/OR use a LO pass,
//   a HI pass and, for ADD/SUB, an optional carry/borrow FIX pass. The result and
//   Z/N/C/O flags are returned over a valid/ready response channel.
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   cmd_valid/ready         command handshake; cmd_op, cmd_wide, cmd_a, cmd_b payload
//   alu_a, alu_b, alu_ctrl  drive to the ALU (combinational from state)
//   alu_result, alu_z/n/c/o ALU result and flags (SUB C = 1 means no borrow)
//   rsp_valid/ready         response handshake; rsp_result, rsp_z/n/c/o payload
// Optional (macro ALU_ISSUE_STICKY_OVF_EN):
//   sticky_clr, sticky_ovf  sticky overflow flag, set on a response with rsp_o=1
module alu_issue_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [2:0]         cmd_op,
  input  logic               cmd_wide,
  input  logic [2*WIDTH-1:0] cmd_a,
  input  logic [2*WIDTH-1:0] cmd_b,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [2:0]         alu_ctrl,
  input  logic [WIDTH-1:0]   alu_result,
  input  logic               alu_z,
  input  logic               alu_n,
  input  logic               alu_c,
  input  logic               alu_o,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [2*WIDTH-1:0] rsp_result,
  output logic               rsp_z,
  output logic               rsp_n,
  output logic               rsp_c,
  output logic               rsp_o
`ifdef ALU_ISSUE_STICKY_OVF_EN
  ,
  input  logic               sticky_clr,
  output logic               sticky_ovf
`endif
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;

  typedef enum logic [2:0] {IDLE, LO, HI, FIX, RSP} state_t;

  state_t             r_state;
  logic [2:0]         r_op;
  logic               r_wide;
  logic [2*WIDTH-1:0] r_a;
  logic [2*WIDTH-1:0] r_b;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_hi;
  logic               r_c_lo;
  logic               r_c_hi;
  logic               r_rsp_valid;
  logic [2*WIDTH-1:0] r_rsp_result;
  logic               r_rsp_z, r_rsp_n, r_rsp_c, r_rsp_o;

  logic               w_fix_needed;
  logic               w_wide_c;
  logic [2*WIDTH-1:0] w_wide_res;
  logic [3:0]         w_wide_flags;

  // Flags of a completed double-width operation, evaluated on the full 2*WIDTH value.
  function automatic logic [3:0] wide_flags(input logic [2:0] op,
                                            input logic [2*WIDTH-1:0] a,
                                            input logic [2*WIDTH-1:0] b,
                                            input logic [2*WIDTH-1:0] r,
                                            input logic c);
    logic z, n, c_o, o;
    z   = (r == '0);
    n   = r[2*WIDTH-1];
    c_o = 1'b0;
    o   = 1'b0;
    case (op)
      OP_ADD: begin
        c_o = c;
        o   = ~(a[2*WIDTH-1] ^ b[2*WIDTH-1]) & (r[2*WIDTH-1] ^ a[2*WIDTH-1]);
      end
      OP_SUB: begin
        c_o = c;
        o   = (a[2*WIDTH-1] ^ b[2*WIDTH-1]) & (r[2*WIDTH-1] ^ a[2*WIDTH-1]);
      end
      default: ;
    endcase
    return {z, n, c_o, o};
  endfunction

  always_comb begin
    alu_a    = '0;
    alu_b    = '0;
    alu_ctrl = 3'b000;
    case (r_state)
      LO: begin
        alu_a    = r_a[WIDTH-1:0];
        alu_b    = r_b[WIDTH-1:0];
        alu_ctrl = r_op;
      end
      HI: begin
        alu_a    = r_a[2*WIDTH-1:WIDTH];
        alu_b    = r_b[2*WIDTH-1:WIDTH];
        alu_ctrl = r_op;
      end
      FIX: begin
        alu_a    = r_hi;
        alu_b    = WIDTH'(1);
        alu_ctrl = r_op;
      end
      default: ;
    endcase
  end

  // The final high half arrives from the ALU in either HI (no fix) or FIX, so the
  // wide response is formed combinationally from the current pass and registered on
  // the transition into RSP. Without a FIX pass c_fix defaults make C equal c_hi.
  always_comb begin
    w_fix_needed = ((r_op == OP_ADD) & r_c_lo) | ((r_op == OP_SUB) & ~r_c_lo);
    w_wide_res   = {alu_result, r_lo};
    w_wide_c     = alu_c;
    if (r_state == FIX)
      w_wide_c = (r_op == OP_ADD) ? (r_c_hi | alu_c) : (r_c_hi & alu_c);
    w_wide_flags = wide_flags(r_op, r_a, r_b, w_wide_res, w_wide_c);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_op         <= '0;
      r_wide       <= 1'b0;
      r_a          <= '0;
      r_b          <= '0;
      r_lo         <= '0;
      r_hi         <= '0;
      r_c_lo       <= 1'b0;
      r_c_hi       <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= '0;
      {r_rsp_z, r_rsp_n, r_rsp_c, r_rsp_o} <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (cmd_valid) begin
            r_op    <= cmd_op;
            r_wide  <= cmd_wide & ~cmd_op[2];
            r_a     <= cmd_a;
            r_b     <= cmd_b;
            r_state <= LO;
          end
        end
        LO: begin
          r_lo   <= alu_result;
          r_c_lo <= alu_c;
          if (r_wide) begin
            r_state <= HI;
          end else begin
            r_rsp_result <= {{WIDTH{1'b0}}, alu_result};
            {r_rsp_z, r_rsp_n, r_rsp_c, r_rsp_o} <= {alu_z, alu_n, alu_c, alu_o};
            r_rsp_valid  <= 1'b1;
            r_state      <= RSP;
          end
        end
        HI: begin
          r_hi   <= alu_result;
          r_c_hi <= alu_c;
          if (w_fix_needed) begin
            r_state <= FIX;
          end else begin
            r_rsp_result <= w_wide_res;
            {r_rsp_z, r_rsp_n, r_rsp_c, r_rsp_o} <= w_wide_flags;
            r_rsp_valid  <= 1'b1;
            r_state      <= RSP;
          end
        end
        FIX: begin
          r_hi         <= alu_result;
          r_rsp_result <= w_wide_res;
          {r_rsp_z, r_rsp_n, r_rsp_c, r_rsp_o} <= w_wide_flags;
          r_rsp_valid  <= 1'b1;
          r_state      <= RSP;
        end
        RSP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cmd_ready  = (r_state == IDLE);
  assign rsp_valid  = r_rsp_valid;
  assign rsp_result = r_rsp_result;
  assign rsp_z      = r_rsp_z;
  assign rsp_n      = r_rsp_n;
  assign rsp_c      = r_rsp_c;
  assign rsp_o      = r_rsp_o;

`ifdef ALU_ISSUE_STICKY_OVF_EN
  logic r_sticky_ovf;

  // Set has priority over clear when both happen at the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n)
      r_sticky_ovf <= 1'b0;
    else if ((r_state == RSP) && rsp_ready && r_rsp_o)
      r_sticky_ovf <= 1'b1;
    else if (sticky_clr)
      r_sticky_ovf <= 1'b0;
  end

  assign sticky_ovf = r_sticky_ovf;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: randomized self-checking bench for alu_issue_ctrl.
//   Contains a behavioural model of the combinational ALU attached to the DUT and a
//   reference model computing the expected response with full 2*W arithmetic.
module tb_alu_issue_ctrl;
  localparam int W = 32;

  typedef struct packed {
    logic [2*W-1:0] r;
    logic z, n, c, o;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           cmd_valid;
  logic           cmd_ready;
  logic [2:0]     cmd_op;
  logic           cmd_wide;
  logic [2*W-1:0] cmd_a, cmd_b;
  logic [W-1:0]   alu_a, alu_b;
  logic [2:0]     alu_ctrl;
  logic [W-1:0]   alu_result;
  logic           alu_z, alu_n, alu_c, alu_o;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [2*W-1:0] rsp_result;
  logic           rsp_z, rsp_n, rsp_c, rsp_o;
`ifdef ALU_ISSUE_STICKY_OVF_EN
  logic           sticky_clr;
  logic           sticky_ovf;
`endif

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;
  logic        exp_sticky = 1'b0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_wide(cmd_wide),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_result(alu_result),
    .alu_z(alu_z), .alu_n(alu_n), .alu_c(alu_c), .alu_o(alu_o),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_z(rsp_z), .rsp_n(rsp_n), .rsp_c(rsp_c), .rsp_o(rsp_o)
`ifdef ALU_ISSUE_STICKY_OVF_EN
    , .sticky_clr(sticky_clr), .sticky_ovf(sticky_ovf)
`endif
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Single-width ALU behaviour; also the expected response for non-wide commands.
  function automatic exp_t alu_fn(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t       e;
    logic [W:0] s;
    logic [W-1:0] r;
    logic       c, o;
    c = 1'b0;
    o = 1'b0;
    case (op)
      3'd0: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[W-1:0];
        c = s[W];
        o = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end
      3'd1: begin
        r = a - b;
        c = (a >= b);
        o = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a << b[4:0];
      3'd5: r = a >> b[4:0];
      default: r = '0;
    endcase
    e.r = {{W{1'b0}}, r};
    e.z = (r == '0);
    e.n = r[W-1];
    e.c = c;
    e.o = o;
    return e;
  endfunction

  exp_t alu_e;
  always_comb begin
    alu_e      = alu_fn(alu_ctrl, alu_a, alu_b);
    alu_result = alu_e.r[W-1:0];
    alu_z      = alu_e.z;
    alu_n      = alu_e.n;
    alu_c      = alu_e.c;
    alu_o      = alu_e.o;
  end

  function automatic exp_t ref_model(input logic [2:0] op, input logic wide,
                                     input logic [2*W-1:0] a, input logic [2*W-1:0] b);
    exp_t         e;
    logic [2*W:0] s;
    logic [2*W-1:0] r;
    logic         c, o;
    if (!wide || op > 3'd3) return alu_fn(op, a[W-1:0], b[W-1:0]);
    c = 1'b0;
    o = 1'b0;
    case (op)
      3'd0: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[2*W-1:0];
        c = s[2*W];
        o = (a[2*W-1] == b[2*W-1]) && (r[2*W-1] != a[2*W-1]);
      end
      3'd1: begin
        r = a - b;
        c = (a >= b);
        o = (a[2*W-1] != b[2*W-1]) && (r[2*W-1] != a[2*W-1]);
      end
      3'd2: r = a & b;
      default: r = a | b;
    endcase
    e.r = r;
    e.z = (r == '0);
    e.n = r[2*W-1];
    e.c = c;
    e.o = o;
    return e;
  endfunction

  // Edges from accept to rsp_valid, counting the accept edge.
  function automatic int exp_latency(input logic [2:0] op, input logic wide,
                                     input logic [2*W-1:0] a, input logic [2*W-1:0] b);
    logic [W:0] lo_sum;
    if (!wide || op > 3'd3) return 2;
    lo_sum = {1'b0, a[W-1:0]} + {1'b0, b[W-1:0]};
    if (op == 3'd0 && lo_sum[W]) return 4;
    if (op == 3'd1 && (a[W-1:0] < b[W-1:0])) return 4;
    return 3;
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  task automatic run_op(input logic [2:0] op, input logic wide, input logic [2*W-1:0] a,
                        input logic [2*W-1:0] b, input int hold, input logic clr);
    exp_t e;
    int   lat;
    e = ref_model(op, wide, a, b);
`ifdef ALU_ISSUE_STICKY_OVF_EN
    if (clr) begin
      @(negedge clk);
      sticky_clr = 1'b1;
      @(posedge clk);
      #1;
      sticky_clr = 1'b0;
      exp_sticky = 1'b0;
      check_eq("sticky_clr", 64'(sticky_ovf), 64'(exp_sticky));
    end
`else
    if (clr) @(negedge clk);
`endif
    @(negedge clk);
    check_eq("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    cmd_op    = op;
    cmd_wide  = wide;
    cmd_a     = a;
    cmd_b     = b;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_eq("latency", 64'(lat), 64'(exp_latency(op, wide, a, b)));
    check_eq("result", rsp_result, e.r);
    check_eq("flags_zncо", 64'({rsp_z, rsp_n, rsp_c, rsp_o}), 64'({e.z, e.n, e.c, e.o}));
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      #1;
      check_eq("hold_valid", 64'({rsp_valid, cmd_ready}), 64'b10);
      check_eq("hold_result", rsp_result, e.r);
      check_eq("hold_flags", 64'({rsp_z, rsp_n, rsp_c, rsp_o}), 64'({e.z, e.n, e.c, e.o}));
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    if (e.o) exp_sticky = 1'b1;
    check_eq("post_hs", 64'({rsp_valid, cmd_ready}), 64'b01);
`ifdef ALU_ISSUE_STICKY_OVF_EN
    check_eq("sticky", 64'(sticky_ovf), 64'(exp_sticky));
`endif
  endtask

  task automatic reset_mid_hi();
    @(negedge clk);
    cmd_op    = 3'd0;
    cmd_wide  = 1'b1;
    cmd_a     = 64'h1234_5678_FFFF_FFFF;
    cmd_b     = 64'h0000_0001_0000_0001;
    cmd_valid = 1'b1;
    @(posedge clk);            // accept, now LO
    #1;
    cmd_valid = 1'b0;
    @(posedge clk);            // now HI
    #1;
    check_eq("in_hi_ctrl", 64'({alu_ctrl, alu_a}), 64'({3'd0, 32'h1234_5678}));
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_sticky = 1'b0;
    check_eq("rst_mid_state", 64'({rsp_valid, cmd_ready}), 64'b01);
    check_eq("rst_mid_result", rsp_result, 64'd0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      check_eq("rst_no_rsp", 64'(rsp_valid), 64'd0);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_wide  = 1'b0;
    cmd_a     = '0;
    cmd_b     = '0;
    rsp_ready = 1'b0;
`ifdef ALU_ISSUE_STICKY_OVF_EN
    sticky_clr = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_eq("rst_valid_ready", 64'({rsp_valid, cmd_ready}), 64'b01);
    check_eq("rst_result", rsp_result, 64'd0);
    check_eq("rst_flags", 64'({rsp_z, rsp_n, rsp_c, rsp_o}), 64'd0);
    check_eq("rst_alu_drive", 64'({alu_ctrl, alu_a, alu_b}), 64'd0);
`ifdef ALU_ISSUE_STICKY_OVF_EN
    check_eq("rst_sticky", 64'(sticky_ovf), 64'd0);
`endif

    // Directed boundary cases
    run_op(3'd0, 1'b0, 64'h0000_0000_FFFF_FFFF, 64'd1, 0, 1'b0);
    run_op(3'd0, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, 0, 1'b0);
    run_op(3'd1, 1'b1, 64'h0000_0001_0000_0000, 64'd1, 0, 1'b0);
    run_op(3'd1, 1'b1, 64'd0, 64'd1, 0, 1'b0);
    run_op(3'd0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 5, 1'b0);
    run_op(3'd2, 1'b0, 64'hFFFF_FFFF_0000_0000, 64'd5, 2, 1'b0);
    run_op(3'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0, 1'b0);
    run_op(3'd6, 1'b1, 64'h1234, 64'h5678, 1, 1'b1);
    run_op(3'd4, 1'b1, 64'hFFFF_FFFF_8000_0001, 64'd4, 0, 1'b0);
    reset_mid_hi();

    for (int i = 0; i < 300; i++) begin
      logic [2:0] op;
      op = 3'($urandom_range(0, 7));
      run_op(op, 1'($urandom_range(0, 1)), {pick(), pick()}, {pick(), pick()},
             $urandom_range(0, 3), ($urandom_range(0, 7) == 0));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Command-side sequencer that acts as the initiator for the combinational ALU. It accepts operations over a valid/ready command channel and drives the ALU operand and opcode inputs.
- Captures the ALU result and Z/N/C/O flags in registers, and returns them over a valid/ready response channel.
- Builds double-width ADD/SUB (carry/borrow fix-up pass) and AND/OR from multiple single-width ALU passes.
- Sits between the decode/issue logic and one ALU instance.

Parameters:
- WIDTH, 32, ALU datapath width. Command/response data is 2*WIDTH.

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  synchronous active-low reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  block can accept a command
- cmd_op  input  3  ALU opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLL, 101 SRL, 110/111 reserved
- cmd_wide  input  1  double-width request
- cmd_a  input  2*WIDTH  operand A
- cmd_b  input  2*WIDTH  operand B
- alu_a  output  WIDTH  ALU operand A
- alu_b  output  WIDTH  ALU operand B
- alu_ctrl  output  3  ALU opcode
- alu_result  input  WIDTH  ALU result
- alu_z, alu_n, alu_c, alu_o  input  1 each  ALU flags (SUB C = 1 means no borrow)
- rsp_valid  output  1  response present
- rsp_ready  input  1  consumer accepts response
- rsp_result  output  2*WIDTH  final result
- rsp_z, rsp_n, rsp_c, rsp_o  output  1 each  final flags

Behaviour:
- Reset: rst_n low at a clock edge puts the FSM in IDLE. rsp_valid=0, rsp_result=0, all rsp flags=0, internal operand/op registers=0. Reset mid-operation abandons the command and produces no response.
- FSM states: IDLE, LO, HI, FIX, RSP.
- cmd_ready=1 only in IDLE. Handshake occurs when cmd_valid & cmd_ready at an edge. On handshake, latch op/wide/a/b and go to LO.
- Effective wide = cmd_wide & (op is ADD, SUB, AND or OR). cmd_wide is ignored for 100-111.
- ALU drive is combinational from state and registers. In IDLE and RSP, alu_a=alu_b=0 and alu_ctrl=000.
- LO pass:
  - Drives a[WIDTH-1:0], b[WIDTH-1:0], op.
  - At the edge, captures result into low half and saves C.
  - Next state is HI if wide, else RSP.
- HI pass:
  - Drives upper halves, op.
  - At the edge, captures the high half and the high C.
  - Goes to FIX if (ADD and low C=1) or (SUB and low C=0); otherwise goes to RSP.
- FIX pass:
  - Drives alu_a = captured high half, alu_b = 1, alu_ctrl = op (ADD increments, SUB decrements).
  - At the edge, replaces the high half and saves the fix C.
  - Next state is RSP.
- Latency from the accept edge to rsp_valid rising: single 2 edges; wide without fix 3; wide with fix 4.
- Single-width response:
  - rsp_result = {WIDTH zeros, low result}.
  - Flags taken from the ALU at the LO pass.
- Wide response flags:
  - Z = (rsp_result == 0); N = rsp_result[2*WIDTH-1].
  - ADD: C = c_hi | c_fix (c_fix=0 if no FIX).
  - SUB: C = c_hi & c_fix (c_fix=1 if no FIX).
  - O computed on full 2*WIDTH MSBs:
    - ADD: ~(a^b) & (r^a).
    - SUB: (a^b) & (r^a).
  - AND/OR: C=O=0.
- RSP: rsp_valid=1. Outputs are held stable until rsp_ready=1 at an edge, then go to IDLE and clear rsp_valid. No new command is accepted in the RSP cycle.
- Reserved opcodes are passed to the ALU unchanged. The response is whatever the ALU returns (zero result, Z=1).
- Wrap-around: wide ADD overflow past 2*WIDTH bits truncates; C reports it.

Optional Feature:
- Macro ALU_ISSUE_STICKY_OVF_EN.
- When defined, adds two ports:
  - input sticky_clr (1)
  - output sticky_ovf (1)
- sticky_ovf is set on any response handshake with rsp_o=1, and cleared by sticky_clr at an edge. Set wins over clear in the same cycle. Reset value is 0.
- When undefined, the ports and register are absent; behaviour is otherwise identical.

Test Plan:
- Single ADD a=0xFFFFFFFF, b=1, wide=0:
  - rsp_result=0x0, Z=1, C=1, O=0.
  - rsp_valid rises 2 edges after accept.
- Wide ADD a=0x00000000_FFFFFFFF, b=1:
  - FIX pass taken; rsp_result=0x00000001_00000000, C=0, Z=0.
  - rsp_valid rises 4 edges after accept.
- Wide SUB a=0x00000001_00000000, b=1:
  - rsp_result=0x00000000_FFFFFFFF, C=1 (no borrow).
- Wide SUB a=0, b=1:
  - rsp_result=0xFFFFFFFF_FFFFFFFF, C=0, N=1, O=0.
- Wide ADD a=0x7FFFFFFF_FFFFFFFF, b=1:
  - O=1, N=1.
  - With ALU_ISSUE_STICKY_OVF_EN, sticky_ovf=1 after handshake and stays 1 until sticky_clr.
- Backpressure and reset:
  - Hold rsp_ready=0 for 5 cycles: rsp outputs stable and cmd_ready=0 throughout.
  - rst_n=0 during the HI state: next cycle IDLE, rsp_valid=0, no response emitted.
